// File: rtl/card_deck_dealer_pkg.sv
// card_pkg: deck constants, card index decode and dealer FSM states
package card_pkg;
    localparam int DECK_SIZE = 52;
    localparam int NUM_RANKS = 13;
    typedef logic [5:0] card_idx_t;
    typedef logic [3:0] rank_t;
    localparam rank_t RANK_A = 4'd1;
    localparam rank_t RANK_J = 4'd11;
    localparam rank_t RANK_Q = 4'd12;
    localparam rank_t RANK_K = 4'd13;
    typedef enum logic [1:0] {IDLE, PICK, SWAP} state_t;
    function automatic rank_t idx_to_rank(card_idx_t c);
        return rank_t'(c % card_idx_t'(NUM_RANKS)) + RANK_A;
    endfunction
    function automatic logic [1:0] idx_to_suit(card_idx_t c);
        return 2'(c / card_idx_t'(NUM_RANKS));
    endfunction
endpackage

// File: rtl/card_deck_dealer_if.sv
// card_deck_dealer_if: shuffle/deal handshake between the dealer and the game controller
interface card_deck_dealer_if;
    logic        shuffle_start;
    logic [15:0] entropy_in;
    logic        deal_req;
    logic        deal_valid;
    logic [3:0]  card_rank;
    logic [1:0]  card_suit;
    logic        deal_err;
    logic [5:0]  cards_left;
    logic        busy;
    logic        empty;
    modport master (
        output shuffle_start, entropy_in, deal_req,
        input  deal_valid, card_rank, card_suit, deal_err, cards_left, busy, empty
    );
    modport slave (
        input  shuffle_start, entropy_in, deal_req,
        output deal_valid, card_rank, card_suit, deal_err, cards_left, busy, empty
    );
endinterface

// File: rtl/card_lfsr16.sv
// card_lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11);
// a load of zero would lock the register, so SEED is substituted.
module card_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] q
);
    logic [15:0] q_q, q_d;
    always_comb begin
        q_d = load ? ((load_val != '0) ? load_val : SEED)
                   : {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
    end
    always_ff @(posedge clk) begin
        q_q <= rst ? SEED : q_d;
    end
    assign q = q_q;
endmodule

// File: rtl/card_deck_dealer.sv
// card_deck_dealer: 52-card deck with in-place Fisher-Yates shuffle and
// one-card-per-request dealing without replacement.
module card_deck_dealer
    import card_pkg::*;
#(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          DECK_SIZE = card_pkg::DECK_SIZE
) (
    input logic clk,
    input logic rst,
    card_deck_dealer_if.slave bus
);
    localparam card_idx_t FULL = card_idx_t'(DECK_SIZE);
    state_t      state_q, state_d;
    card_idx_t   ptr_q, ptr_d, i_q, i_d, j_q, j_d;
    card_idx_t   deck_q [DECK_SIZE];
    logic        valid_q, valid_d, err_q, err_d;
    rank_t       rank_q, rank_d;
    logic [1:0]  suit_q, suit_d;
    logic        load, swap;
    logic [15:0] rnd;
    card_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk(clk), .rst(rst), .load(load), .load_val(rnd ^ bus.entropy_in), .q(rnd)
    );
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        i_d     = i_q;
        j_d     = j_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        rank_d  = rank_q;
        suit_d  = suit_q;
        load    = 1'b0;
        swap    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.shuffle_start) begin
                    load    = 1'b1;
                    i_d     = FULL - 6'd1;
                    state_d = PICK;
                end else if (bus.deal_req) begin
                    valid_d = ptr_q < FULL;
                    err_d   = ptr_q >= FULL;
                    rank_d  = (ptr_q < FULL) ? idx_to_rank(deck_q[ptr_q]) : rank_q;
                    suit_d  = (ptr_q < FULL) ? idx_to_suit(deck_q[ptr_q]) : suit_q;
                    ptr_d   = (ptr_q < FULL) ? ptr_q + 6'd1 : ptr_q;
                end
            end
            // rejection sampling: retry until the low LFSR bits land in 0..i
            PICK: begin
                j_d     = (rnd[5:0] <= i_q) ? rnd[5:0] : j_q;
                state_d = (rnd[5:0] <= i_q) ? SWAP : PICK;
            end
            SWAP: begin
                swap    = 1'b1;
                i_d     = i_q - 6'd1;
                ptr_d   = (i_q == 6'd1) ? '0 : ptr_q;
                state_d = (i_q == 6'd1) ? IDLE : PICK;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rank_q  <= '0;
            suit_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            i_q     <= i_d;
            j_q     <= j_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rank_q  <= rank_d;
            suit_q  <= suit_d;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DECK_SIZE; k++) deck_q[k] <= card_idx_t'(k);
        end else if (swap) begin
            deck_q[i_q] <= deck_q[j_q];
            deck_q[j_q] <= deck_q[i_q];
        end
    end
    assign bus.deal_valid = valid_q;
    assign bus.deal_err   = err_q;
    assign bus.card_rank  = rank_q;
    assign bus.card_suit  = suit_q;
    assign bus.cards_left = FULL - ptr_q;
    assign bus.empty      = ptr_q == FULL;
    assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_card_deck_dealer.sv
// tb_card_deck_dealer: directed checks of dealing, exhaustion, shuffle permutation,
// blocked requests, mid-shuffle reset and the zero-mix seed substitution.
module tb_card_deck_dealer;
    localparam logic [15:0] SEED = 16'hACE1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    card_deck_dealer_if bus();
    card_deck_dealer #(.SEED(SEED), .DECK_SIZE(52)) dut (.clk(clk), .rst(rst), .bus(bus));
    int n_tests = 0;
    int n_fail = 0;
    logic [15:0] m_lfsr;
    logic        m_load = 1'b0;
    int m_deck [52];
    int m_ptr;
    int cur [52];
    int seq_a [52];
    function automatic logic [15:0] step(logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction
    function automatic logic [15:0] mixsub(logic [15:0] q, logic [15:0] e);
        return ((q ^ e) == 16'h0) ? SEED : (q ^ e);
    endfunction
    always @(posedge clk) m_lfsr <= rst ? SEED : m_load ? mixsub(m_lfsr, bus.entropy_in) : step(m_lfsr);
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.shuffle_start = 1'b0;
        bus.deal_req = 1'b0;
        m_load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 52; k++) m_deck[k] = k;
        m_ptr = 0;
    endtask
    task automatic deal(output int id);
        int c;
        bus.deal_req = 1'b1;
        @(negedge clk);
        bus.deal_req = 1'b0;
        c = m_deck[m_ptr];
        m_ptr++;
        check("deal_valid", bus.deal_valid, 1);
        check("rank", bus.card_rank, c % 13 + 1);
        check("suit", bus.card_suit, c / 13);
        check("cards_left", bus.cards_left, 52 - m_ptr);
        check("empty", bus.empty, m_ptr == 52);
        id = (bus.card_rank >= 1 && bus.card_rank <= 13) ? bus.card_suit * 13 + bus.card_rank - 1 : -1;
        @(negedge clk);
        check("valid_pulse", bus.deal_valid, 0);
    endtask
    task automatic deal_all();
        logic [51:0] seen;
        int c;
        seen = '0;
        for (int k = 0; k < 52; k++) begin
            deal(c);
            cur[k] = c;
            if (c >= 0 && c < 52) seen[c] = 1'b1;
        end
        check("unique_cards", $countones(seen), 52);
    endtask
    task automatic shuffle(logic [15:0] ent, logic with_deal, logic poke);
        logic [15:0] q;
        int j, t, steps, cyc, strobes, moved;
        logic [3:0] rank0;
        q = mixsub(m_lfsr, ent);
        steps = 0;
        for (int i = 51; i >= 1; i--) begin
            while (int'(q[5:0]) > i) begin
                q = step(q);
                steps++;
            end
            j = int'(q[5:0]);
            q = step(step(q));
            steps += 2;
            t = m_deck[i];
            m_deck[i] = m_deck[j];
            m_deck[j] = t;
        end
        m_ptr = 0;
        rank0 = bus.card_rank;
        bus.entropy_in = ent;
        bus.shuffle_start = 1'b1;
        bus.deal_req = with_deal;
        m_load = 1'b1;
        @(negedge clk);
        bus.shuffle_start = 1'b0;
        bus.deal_req = 1'b0;
        m_load = 1'b0;
        cyc = 0;
        strobes = 0;
        moved = 0;
        while (bus.busy === 1'b1 && cyc < 5000) begin
            if (bus.deal_valid !== 1'b0 || bus.deal_err !== 1'b0) strobes++;
            if (bus.card_rank !== rank0) moved++;
            bus.deal_req = poke && (cyc % 5 == 2);
            bus.shuffle_start = poke && (cyc % 11 == 4);
            bus.entropy_in = 16'h7777;
            cyc++;
            @(negedge clk);
            bus.deal_req = 1'b0;
            bus.shuffle_start = 1'b0;
        end
        check("busy_cycles", cyc, steps);
        check("busy_min_102", cyc >= 102, 1);
        check("no_strobe_busy", strobes, 0);
        check("rank_held_busy", moved, 0);
        check("left_after_shuf", bus.cards_left, 52);
        check("empty_after_shuf", bus.empty, 0);
        check("strobe_after_shuf", bus.deal_valid | bus.deal_err, 0);
    endtask
    initial begin
        int diff;
        bus.shuffle_start = 1'b0;
        bus.deal_req = 1'b0;
        bus.entropy_in = 16'h0;
        do_reset();
        check("rst_valid", bus.deal_valid, 0);
        check("rst_err", bus.deal_err, 0);
        check("rst_rank", bus.card_rank, 0);
        check("rst_suit", bus.card_suit, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_empty", bus.empty, 0);
        check("rst_left", bus.cards_left, 52);
        deal_all();
        check("ord_card1", cur[0], 0);
        check("ord_card13", cur[12], 12);
        check("ord_card14", cur[13], 13);
        check("ord_card52", cur[51], 51);
        bus.deal_req = 1'b1;
        @(negedge clk);
        bus.deal_req = 1'b0;
        check("err_strobe", bus.deal_err, 1);
        check("err_no_valid", bus.deal_valid, 0);
        check("err_rank_held", bus.card_rank, 13);
        check("err_suit_held", bus.card_suit, 3);
        check("err_left", bus.cards_left, 0);
        check("err_empty", bus.empty, 1);
        @(negedge clk);
        check("err_pulse", bus.deal_err, 0);
        do_reset();
        repeat (5) @(negedge clk);
        shuffle(16'h1234, 1'b0, 1'b0);
        deal_all();
        seq_a = cur;
        diff = 0;
        for (int k = 0; k < 52; k++) if (seq_a[k] != k) diff++;
        check("shuffled_order", diff != 0, 1);
        do_reset();
        repeat (5) @(negedge clk);
        shuffle(16'h1234, 1'b0, 1'b0);
        deal_all();
        diff = 0;
        for (int k = 0; k < 52; k++) if (cur[k] != seq_a[k]) diff++;
        check("repeat_identical", diff, 0);
        shuffle(16'h5A5A, 1'b1, 1'b1);
        deal_all();
        do_reset();
        bus.entropy_in = 16'hBEEF;
        bus.shuffle_start = 1'b1;
        @(negedge clk);
        bus.shuffle_start = 1'b0;
        repeat (39) @(negedge clk);
        check("mid_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_left", bus.cards_left, 52);
        for (int k = 0; k < 52; k++) m_deck[k] = k;
        m_ptr = 0;
        begin
            int c;
            deal(c);
            check("mid_rst_first", c, 0);
        end
        do_reset();
        repeat (3) @(negedge clk);
        shuffle(m_lfsr, 1'b0, 1'b0);
        check("zero_mix_idle", bus.busy, 0);
        deal_all();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
